// File: rtl/wave_display_multi.sv
// Multi-channel waveform overlay: draws NUM_CH sample traces as connected segments
// onto the pixel stream, reading all channels through one shared sample-RAM port.

module wave_trace_ch #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                have_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] target,
  input  logic                qual,
  input  logic                en,
  output logic                hit_nxt
);
  logic [SAMPLE_W-1:0] cur, prev, lo, hi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= '0;
      prev <= '0;
    end else if (load) begin
      // first sample of a line has no predecessor: draw it as a single point
      prev <= have_sample ? cur : sample;
      cur  <= sample;
    end
  end

  always_comb begin
    lo      = (prev < cur) ? prev : cur;
    hi      = (prev < cur) ? cur  : prev;
    hit_nxt = qual && en && (lo <= target) && (target <= hi);
  end
endmodule

module wave_display_multi #(
  parameter int                    NUM_CH   = 2,
  parameter int                    SAMPLE_W = 8,
  parameter int                    ADDR_W   = 9,
  parameter int                    X_W      = 11,
  parameter int                    Y_W      = 10,
  parameter int                    X_START  = 256,
  parameter int                    Y_TOP    = 256,
  parameter logic [NUM_CH*24-1:0]  CH_RGB   = 48'hFF00FF_00FF00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [X_W-1:0]             x,
  input  logic [Y_W-1:0]             y,
  input  logic                       valid,
  input  logic                       read_index,
  input  logic [NUM_CH-1:0]          ch_enable,
  output logic [ADDR_W-1:0]          read_address,
  input  logic [NUM_CH*SAMPLE_W-1:0] read_value,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b,
  output logic                       valid_out,
  output logic [NUM_CH-1:0]          hit
);
  localparam int STAGES = 3;
  localparam logic [X_W-1:0] X0    = X_W'(X_START);
  localparam logic [X_W-1:0] XSPAN = X_W'(2**ADDR_W);
  localparam logic [Y_W-1:0] Y0    = Y_W'(Y_TOP);
  localparam logic [Y_W-1:0] YSPAN = Y_W'(2**(SAMPLE_W+1));

  typedef struct packed {
    logic                in_x;
    logic                in_y;
    logic [SAMPLE_W-1:0] target;
    logic [ADDR_W-1:0]   addr;
  } pix_t;

  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      ry;
  logic [SAMPLE_W-1:0] yv;
  pix_t                pix, s1, s2;
  logic [STAGES:1]     vld_pipe;
  logic [ADDR_W-1:0]   last_addr;
  logic                have_sample, new_smp, qual;
  logic [NUM_CH-1:0]   hit_nxt;
  logic [23:0]         rgb_nxt;

  always_comb begin
    cx         = x - X0;
    ry         = y - Y0;
    yv         = ry[SAMPLE_W:1];
    pix.in_x   = (x >= X0) && (cx < XSPAN);
    pix.in_y   = (y >= Y0) && (ry < YSPAN);
    pix.target = ~yv;
    pix.addr   = {read_index, cx[ADDR_W-1:1]};
  end

  assign read_address = pix.addr;

  // a line break or reset leaves last_addr stale, so an empty history always loads
  assign new_smp = vld_pipe[1] && s1.in_x && ((s1.addr != last_addr) || !have_sample);
  assign qual    = vld_pipe[2] && s2.in_x && s2.in_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      s1          <= '0;
      s2          <= '0;
      last_addr   <= '0;
      have_sample <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], valid};
      s1       <= pix;
      s2       <= s1;
      if (new_smp) begin
        last_addr   <= s1.addr;
        have_sample <= 1'b1;
      end else if (vld_pipe[1] && !s1.in_x) begin
        have_sample <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    wave_trace_ch #(.SAMPLE_W(SAMPLE_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load       (new_smp),
      .have_sample(have_sample),
      .sample     (read_value[k*SAMPLE_W +: SAMPLE_W]),
      .target     (s2.target),
      .qual       (qual),
      .en         (ch_enable[k]),
      .hit_nxt    (hit_nxt[k])
    );
  end

  // lowest-index lit channel wins
  always_comb begin
    rgb_nxt = '0;
    for (int k = NUM_CH-1; k >= 0; k--)
      if (hit_nxt[k]) rgb_nxt = CH_RGB[k*24 +: 24];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      hit       <= '0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else begin
      valid_out   <= vld_pipe[STAGES-1];
      hit         <= hit_nxt;
      {r, g, b}   <= rgb_nxt;
    end
  end
endmodule

// File: tb/tb_wave_display_multi.sv
// Bench for wave_display_multi: directed scenes plus random sweeps against a
// per-pixel reference model of the trace-drawing rules.
module tb_wave_display_multi;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid, read_index;
  logic [1:0]  ch_enable;
  logic [8:0]  read_address;
  logic [15:0] read_value;
  logic [7:0]  r, g, b;
  logic        valid_out;
  logic [1:0]  hit;

  int checks = 0;
  int failures = 0;

  wave_display_multi dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
    .ch_enable(ch_enable), .read_address(read_address), .read_value(read_value),
    .r(r), .g(g), .b(b), .valid_out(valid_out), .hit(hit)
  );

  always #5 clk = ~clk;

  // sample RAM, one-cycle read latency
  logic [7:0]  mem [2][512];
  logic [15:0] rd_q;
  always @(posedge clk) rd_q <= {mem[1][read_address], mem[0][read_address]};
  assign read_value = rd_q;

  // reference model state
  typedef struct {
    bit              v;
    bit              w;
    int              t;
    logic [1:0][7:0] lo;
    logic [1:0][7:0] hi;
  } exp_t;
  exp_t q[$];
  bit   have;
  int   last;
  int   cur [2];
  int   prev[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_t z;
    z.v = 0; z.w = 0; z.t = 0; z.lo = '0; z.hi = '0;
    have = 0; last = 0;
    for (int k = 0; k < 2; k++) begin cur[k] = 0; prev[k] = 0; end
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [1:0] eh;
    logic [23:0] rgb;
    e  = q.pop_front();
    eh = '0;
    for (int k = 0; k < 2; k++)
      if (e.w && ch_enable[k] && int'(e.lo[k]) <= e.t && e.t <= int'(e.hi[k])) eh[k] = 1'b1;
    rgb = eh[0] ? 24'h00FF00 : (eh[1] ? 24'hFF00FF : 24'h000000);
    chk("pix", 64'({valid_out, hit, r, g, b}), 64'({e.v, eh, rgb}));
  endtask

  // one pixel per clock; called at posedge+1
  task automatic pix(input int px, input int py, input bit pv, input bit pri);
    exp_t e;
    bit   inx, iny;
    int   addr, s;
    x = 11'(px); y = 10'(py); valid = pv; read_index = pri;
    inx  = (px >= 256) && (px < 768);
    iny  = (py >= 256) && (py < 768);
    addr = int'(pri) * 256 + (px - 256) / 2;
    #1;
    if (inx) chk("addr", 64'(read_address), 64'(addr));
    @(posedge clk); #1;
    if (pv && inx && (!have || addr != last)) begin
      for (int k = 0; k < 2; k++) begin
        s       = int'(mem[k][addr]);
        prev[k] = have ? cur[k] : s;
        cur[k]  = s;
      end
      have = 1; last = addr;
    end else if (pv && !inx) begin
      have = 0;
    end
    e.v = pv;
    e.w = pv && inx && iny;
    e.t = iny ? 255 - (py - 256) / 2 : 0;
    for (int k = 0; k < 2; k++) begin
      e.lo[k] = 8'((prev[k] < cur[k]) ? prev[k] : cur[k]);
      e.hi[k] = 8'((prev[k] < cur[k]) ? cur[k] : prev[k]);
    end
    q.push_back(e);
    if (q.size() > 2) check_out();
  endtask

  task automatic line(input int py, input int x0, input int x1, input bit pri);
    for (int i = x0; i <= x1; i++) pix(i, py, 1'b1, pri);
  endtask

  task automatic fill(input int k, input int v);
    for (int i = 0; i < 512; i++) mem[k][i] = 8'(v);
  endtask

  initial begin
    bit ri;
    int yy;
    fill(0, 0); fill(1, 0);
    reset = 1'b0; x = 11'd300; y = 10'd300; valid = 1'b1; read_index = 1'b1; ch_enable = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'({valid_out, hit, r, g, b}), 64'd0);
    chk("rst_addr", 64'(read_address), 64'd278);
    model_clear();
    reset = 1'b1;

    // flat traces
    fill(0, 128); fill(1, 0);
    for (int l = 510; l <= 512; l++) line(l, 255, 768, 1'b0);

    // ramp on ch0
    for (int i = 0; i < 512; i++) mem[0][i] = 8'(i);
    for (int l = 744; l <= 750; l++) line(l, 255, 280, 1'b0);

    // overlap and priority, enable toggled mid-line
    fill(0, 64); fill(1, 64);
    for (int l = 638; l <= 639; l++) line(l, 255, 270, 1'b0);
    ch_enable = 2'b10; line(638, 255, 270, 1'b0);
    ch_enable = 2'b00; line(639, 255, 270, 1'b0);
    for (int i = 256; i < 280; i++) begin
      ch_enable = 2'(i % 4);
      pix(i, 638, 1'b1, 1'b0);
    end
    ch_enable = 2'b11;

    // window edges and line join
    fill(1, 0);
    for (int i = 0; i < 512; i++) mem[0][i] = 8'($urandom_range(0, 255));
    mem[0][255] = 8'd50; mem[0][0] = 8'd200;
    line(666, 700, 768, 1'b0);
    line(366, 255, 262, 1'b0);
    line(666, 255, 262, 1'b0);
    line(367, 760, 770, 1'b0);
    line(367, 255, 258, 1'b0);

    // asynchronous reset mid-line
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 8'($urandom_range(0, 255));
      mem[1][i] = 8'($urandom_range(0, 255));
    end
    line(500, 380, 400, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid", 64'({valid_out, hit, r, g, b}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 64'({valid_out, hit, r, g, b}), 64'd0);
    model_clear();
    reset = 1'b1;
    pix(400, 500, 1'b0, 1'b1);
    line(500, 400, 440, 1'b1);

    // random sweeps
    ri = 1'b0;
    for (int l = 0; l < 16; l++) begin
      yy = $urandom_range(240, 780);
      for (int i = 250; i <= 780; i++) begin
        if ($urandom_range(0, 63) == 0) ri = ~ri;
        if ($urandom_range(0, 31) == 0) ch_enable = 2'($urandom);
        pix(i, yy, $urandom_range(0, 7) != 0, ri);
      end
    end

    // drain
    repeat (3) pix(0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
